// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter command front-end.
package updown_pkg;

  // Press-handling FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  // Direction encoding seen by the downstream counter
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Cycles after reset before the synchroniser output reflects the pins
  localparam int unsigned FILL_CYCLES = 2;
  localparam int unsigned FILL_W      = 2;

endpackage : updown_pkg

// File: rtl/updown_cmd_frontend_if.sv
// Button inputs and counter-control outputs of the command front-end.
interface updown_cmd_frontend_if;
  logic btn_up;
  logic btn_down;
  logic step;
  logic dir;
  logic held;

  // Driver of the buttons / consumer of step, dir, held
  modport master (
    output btn_up,
    output btn_down,
    input  step,
    input  dir,
    input  held
  );

  // The front-end itself
  modport slave (
    input  btn_up,
    input  btn_down,
    output step,
    output dir,
    output held
  );
endinterface : updown_cmd_frontend_if

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debounce counter.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync,
  output logic level
);

  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then flip the level only after DEB_CYCLES disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        lvl <= ~lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign sync  = sync2;
  assign level = lvl;

endmodule : btn_debounce

// File: rtl/updown_cmd_frontend.sv
// Push-button front-end: debounced single step on press, auto-repeat on hold,
// lockout while both buttons are involved.
module updown_cmd_frontend
  import updown_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned REPEAT_CYCLES = 16,
  parameter int unsigned TMR_W         = 8
) (
  input logic                  clk,
  input logic                  rst,
  updown_cmd_frontend_if.slave bus
);

  logic deb_up;
  logic deb_dn;
  logic sync_up;
  logic sync_dn;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (TMR_W)
  ) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_up),
    .sync  (sync_up),
    .level (deb_up)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (TMR_W)
  ) u_deb_dn (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_down),
    .sync  (sync_dn),
    .level (deb_dn)
  );

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [FILL_W-1:0]  fill;
  logic               armed;
  logic               step_q;
  logic               dir_q;
  logic               held_q;

  logic               up_v;
  logic               dn_v;
  logic               both;
  logic               none;
  logic               other;
  logic               quiet;
  logic [TMR_W-1:0]   tmr_end;
  logic [TMR_W-1:0]   tmr_nxt;

  // Effective inputs, conflict detection and timer helpers
  always_comb begin
    up_v    = deb_up & ~deb_dn;
    dn_v    = deb_dn & ~deb_up;
    both    = deb_up & deb_dn;
    none    = ~deb_up & ~deb_dn;
    other   = (dir_q == DIR_UP) ? dn_v : up_v;
    quiet   = (fill == FILL_W'(FILL_CYCLES)) & ~sync_up & ~sync_dn & none;
    tmr_end = (state == ST_HOLD) ? TMR_W'(HOLD_CYCLES - 1) : TMR_W'(REPEAT_CYCLES - 1);
    tmr_nxt = (tmr == '1) ? tmr : tmr + TMR_W'(1);
  end

  // Press FSM with registered step/dir/held; a button still held through a
  // reset must be released before it can issue a step again (armed).
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      tmr    <= '0;
      fill   <= '0;
      armed  <= 1'b0;
      step_q <= 1'b0;
      dir_q  <= DIR_UP;
      held_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (fill != FILL_W'(FILL_CYCLES)) fill <= fill + FILL_W'(1);
      if (quiet) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          held_q <= 1'b0;
          if (both) begin
            state <= ST_LOCKOUT;
          end else if (armed && (up_v || dn_v)) begin
            step_q <= 1'b1;
            dir_q  <= up_v ? DIR_UP : DIR_DOWN;
            tmr    <= '0;
            held_q <= 1'b1;
            state  <= ST_HOLD;
          end
        end

        ST_HOLD, ST_REPEAT: begin
          if (both || other) begin
            held_q <= 1'b0;
            state  <= ST_LOCKOUT;
          end else if (none) begin
            held_q <= 1'b0;
            state  <= ST_IDLE;
          end else if (tmr == tmr_end) begin
            step_q <= 1'b1;
            tmr    <= '0;
            state  <= ST_REPEAT;
          end else begin
            tmr <= tmr_nxt;
          end
        end

        ST_LOCKOUT: begin
          held_q <= 1'b0;
          if (none) state <= ST_IDLE;
        end

        default: begin
          held_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.held = held_q;

endmodule : updown_cmd_frontend
